tx_serializer: RTL and testbench

- Upstream neighbour of the receive controller.
- Accepts parallel words from a ready/valid producer and emits them as framed serial bursts on a valid/data pair.
- Frame format: a one-cycle start strobe on tx_valid, then DATA_WIDTH data bits LSB-first on consecutive cycles, then a mandatory idle gap.
- The idle gap lets the downstream controller pass through its Done and Init states before the next strobe.

---
 rtl/tx_serializer.sv | 120 ++++++++++++
 tb/tb_tx_serializer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_serializer.sv
// Parallel-to-serial framer: one-word hold register feeding a start strobe,
// an LSB-first data burst and a mandatory idle gap before the next strobe.
module tx_serializer #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned GAP_CYCLES      = 2,
   parameter logic [15:0] FRAME_COUNT_RST = 16'h0000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  tx_valid,
   output logic                  tx_data,
   output logic                  busy,
   output logic [15:0]           frame_count
);

   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t                  r_state;
   logic [DATA_WIDTH-1:0]   r_hold_data;
   logic                    r_hold_full;
   logic [DATA_WIDTH-1:0]   r_shift;
   logic [BIT_W-1:0]        r_bit_cnt;
   logic [GAP_W-1:0]        r_gap_cnt;
   logic                    r_tx_valid;
   logic                    r_tx_data;
   logic                    r_busy;
   logic [15:0]             r_frame_count;
   logic                    w_accept;

   // in_ready is held low during reset so nothing is accepted into a clearing register
   assign in_ready    = reset & ~r_hold_full;
   assign w_accept    = in_valid & in_ready;
   assign tx_valid    = r_tx_valid;
   assign tx_data     = r_tx_data;
   assign busy        = r_busy;
   assign frame_count = r_frame_count;

   // Framing FSM; outputs are loaded together with the state they belong to
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_hold_data   <= '0;
         r_hold_full   <= 1'b0;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_gap_cnt     <= '0;
         r_tx_valid    <= 1'b0;
         r_tx_data     <= 1'b0;
         r_busy        <= 1'b0;
         r_frame_count <= FRAME_COUNT_RST;
      end else begin
         if (w_accept) begin
            r_hold_data <= in_data;
            r_hold_full <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (r_hold_full) begin
                  r_state    <= S_START;
                  r_tx_valid <= 1'b1;
                  r_busy     <= 1'b1;
               end
            end
            S_START: begin
               r_shift     <= r_hold_data;
               r_hold_full <= 1'b0;
               r_bit_cnt   <= '0;
               r_tx_valid  <= 1'b0;
               r_tx_data   <= r_hold_data[0];
               r_state     <= S_SHIFT;
            end
            S_SHIFT: begin
               r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
               if (r_bit_cnt == BIT_LAST) begin
                  r_frame_count <= r_frame_count + 16'd1;
                  r_gap_cnt     <= '0;
                  r_tx_data     <= 1'b0;
                  r_state       <= S_GAP;
               end else begin
                  r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                  r_tx_data <= r_shift[1];
               end
            end
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  if (r_hold_full) begin
                     r_state    <= S_START;
                     r_tx_valid <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_tx_valid <= 1'b0;
               r_tx_data  <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: default 8/2 build plus a 4/3 build
// preloaded near the frame counter wrap point.
module tb_tx_serializer;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        tx_valid;
   logic        tx_data;
   logic        busy;
   logic [15:0] frame_count;

   logic [3:0]  in_data2;
   logic        in_valid2;
   logic        in_ready2;
   logic        tx_valid2;
   logic        tx_data2;
   logic        busy2;
   logic [15:0] frame_count2;

   int n_chk = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   tx_serializer #(.DATA_WIDTH(8), .GAP_CYCLES(2)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .busy        (busy),
      .frame_count (frame_count)
   );

   tx_serializer #(.DATA_WIDTH(4), .GAP_CYCLES(3), .FRAME_COUNT_RST(16'hFFFE)) dut2 (
      .clock       (clock),
      .reset       (reset),
      .in_data     (in_data2),
      .in_valid    (in_valid2),
      .in_ready    (in_ready2),
      .tx_valid    (tx_valid2),
      .tx_data     (tx_data2),
      .busy        (busy2),
      .frame_count (frame_count2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0]  w_a5;
      logic [7:0]  w_3c;
      logic [7:0]  w_exp8;
      logic [3:0]  w_d;
      logic [15:0] exp_fc;
      int          k;
      int          done;
      int          last_strobe;

      w_a5 = 8'hA5;
      w_3c = 8'h3C;
      w_d  = 4'hD;

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_valid2 = 1'b0;
      in_data2  = 4'h0;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_in_ready2", 32'(in_ready2), 32'd0);
      check("rst_frame_count2", 32'(frame_count2), 32'h0000FFFE);

      @(negedge clock);
      reset = 1'b1;
      tick();
      check("rel_in_ready", 32'(in_ready), 32'd1);
      check("rel_in_ready2", 32'(in_ready2), 32'd1);

      // Single 0xA5 frame, accepted at the edge ending cycle 0
      in_valid = 1'b1;
      in_data  = 8'hA5;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 1) begin
            in_valid = 1'b0;
            in_data  = 8'h00;
         end
         check($sformatf("t1_txv_c%0d", c), 32'(tx_valid), 32'(c == 2));
         check($sformatf("t1_txd_c%0d", c), 32'(tx_data),
               (c >= 3 && c <= 10) ? 32'(w_a5[c-3]) : 32'd0);
         check($sformatf("t1_fc_c%0d", c), 32'(frame_count), (c >= 11) ? 32'd1 : 32'd0);
         check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c >= 2 && c <= 12));
         check($sformatf("t1_rdy_c%0d", c), 32'(in_ready), 32'(!(c == 1 || c == 2)));
      end

      // Back-to-back 0xA5 then 0x3C; in_data churns while in_ready is low
      in_valid = 1'b1;
      in_data  = 8'hA5;
      for (int c = 1; c <= 24; c++) begin
         tick();
         if (c == 1) in_data = 8'hFF;
         if (c == 2) in_data = 8'h3C;
         if (c == 4) begin
            in_valid = 1'b0;
            in_data  = 8'h00;
         end
         if (c >= 3 && c <= 10)       w_exp8 = {7'd0, w_a5[c-3]};
         else if (c >= 14 && c <= 21) w_exp8 = {7'd0, w_3c[c-14]};
         else                         w_exp8 = 8'd0;
         check($sformatf("t2_txv_c%0d", c), 32'(tx_valid), 32'(c == 2 || c == 13));
         check($sformatf("t2_txd_c%0d", c), 32'(tx_data), 32'(w_exp8));
         check($sformatf("t2_fc_c%0d", c), 32'(frame_count),
               32'(1 + ((c >= 11) ? 1 : 0) + ((c >= 22) ? 1 : 0)));
         check($sformatf("t2_busy_c%0d", c), 32'(busy), 32'(c >= 2 && c <= 23));
         check($sformatf("t2_rdy_c%0d", c), 32'(in_ready),
               32'(!((c >= 1 && c <= 2) || (c >= 4 && c <= 13))));
      end

      // Reset in cycle 6 of a frame (0x5A bit 3 = 1 on the line) with 0x96 held
      in_valid = 1'b1;
      in_data  = 8'h5A;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) in_data = 8'h96;
         if (c == 4) begin
            in_valid = 1'b0;
            in_data  = 8'h00;
         end
      end
      check("t4_pre_txd", 32'(tx_data), 32'd1);
      check("t4_pre_rdy", 32'(in_ready), 32'd0);
      reset = 1'b0;
      #1;
      check("t4_rst_txv", 32'(tx_valid), 32'd0);
      check("t4_rst_txd", 32'(tx_data), 32'd0);
      check("t4_rst_fc", 32'(frame_count), 32'd0);
      check("t4_rst_busy", 32'(busy), 32'd0);
      check("t4_rst_rdy", 32'(in_ready), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         tick();
         check($sformatf("t4_txv_c%0d", c), 32'(tx_valid), 32'd0);
         check($sformatf("t4_busy_c%0d", c), 32'(busy), 32'd0);
         check($sformatf("t4_rdy_c%0d", c), 32'(in_ready), 32'd1);
      end
      check("t4_fc_after", 32'(frame_count), 32'd0);

      // 4-bit / 3-gap build, continuous input, counter wraps after two frames
      in_valid2   = 1'b1;
      in_data2    = 4'hD;
      last_strobe = -100;
      for (int c = 1; c <= 40; c++) begin
         tick();
         k    = (c >= 2) ? (c - 2) % 8 : -1;
         done = (c >= 7) ? ((c - 7) / 8 + 1) : 0;
         exp_fc = 16'hFFFE + 16'(done);
         check($sformatf("t5_txv_c%0d", c), 32'(tx_valid2), 32'(k == 0));
         check($sformatf("t5_txd_c%0d", c), 32'(tx_data2),
               (k >= 1 && k <= 4) ? 32'(w_d[k-1]) : 32'd0);
         check($sformatf("t5_fc_c%0d", c), 32'(frame_count2), 32'(exp_fc));
         check($sformatf("t5_busy_c%0d", c), 32'(busy2), 32'(c >= 2));
         check($sformatf("t5_rdy_c%0d", c), 32'(in_ready2),
               32'(c >= 3 && ((c - 3) % 8) == 0));
         if (tx_valid2) begin
            check($sformatf("t5_strobe_spacing_c%0d", c), 32'(c - last_strobe >= 8), 32'd1);
            last_strobe = c;
         end
      end
      check("t5_wrapped_fc", 32'(frame_count2), 32'h00000003);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
